// File: rtl/huffman_stream_encoder.sv
// Maps symbols to variable-length codes and packs them MSB-first into O_W-bit words.
// A full word appears one cycle after cnt reaches O_W; s_ready drops while O_W+ bits are pending.
module huffman_stream_encoder #(
  parameter int NUM_OF_CHARS = 16,
  parameter int D_W          = 4,
  parameter int C_W          = 8,
  parameter int W_W          = 4,
  parameter int O_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [D_W-1:0]        d_conf,
  input  logic [C_W-1:0]        h_conf,
  input  logic [W_W-1:0]        w_conf,
  input  logic                  en_conf,
  input  logic                  new_conf,
  input  logic [D_W-1:0]        s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  flush,
  output logic [O_W-1:0]        o_word,
  output logic [$clog2(O_W):0]  o_bits,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  err_unmapped,
  output logic                  flush_done
);
  localparam int AW    = O_W + C_W;
  localparam int CNT_W = $clog2(AW);
  localparam int OB_W  = $clog2(O_W) + 1;

  typedef enum logic [1:0] {RUN, FLUSH, FDONE} state_t;
  state_t state, state_nxt;

  logic [C_W-1:0]          tbl_code [NUM_OF_CHARS];
  logic [W_W-1:0]          tbl_len  [NUM_OF_CHARS];
  logic [NUM_OF_CHARS-1:0] tbl_vld;

  logic [AW-1:0]    acc, acc_nxt, acc_sh, code_al;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_sh, lsh;
  logic [D_W-1:0]   sym_idx;
  logic [C_W-1:0]   sym_code;
  logic [W_W-1:0]   sym_len;
  logic             conf_wr, sym_ok, sym_hit, slot_free, accept, emit_full, emit_part;

  assign s_ready = (state == RUN) && (cnt < CNT_W'(O_W));
  assign conf_wr = en_conf && !new_conf && (w_conf != '0) && (32'(w_conf) <= C_W)
                   && (32'(d_conf) < NUM_OF_CHARS);

  always_comb begin
    sym_ok    = 32'(s_data) < NUM_OF_CHARS;
    sym_idx   = sym_ok ? s_data : '0;
    sym_hit   = sym_ok && tbl_vld[sym_idx];
    sym_code  = tbl_code[sym_idx];
    sym_len   = tbl_len[sym_idx];
    slot_free = !o_valid || o_ready;
    accept    = s_valid && s_ready && !new_conf;
    emit_full = (cnt >= CNT_W'(O_W)) && slot_free;
    acc_sh    = emit_full ? (acc << O_W) : acc;
    cnt_sh    = emit_full ? (cnt - CNT_W'(O_W)) : cnt;
    // Left shift MSB-aligns the code and drops bits above its length; right shift places it after pending bits.
    lsh       = CNT_W'(AW) - CNT_W'(sym_len);
    code_al   = (AW'(sym_code) << lsh) >> cnt_sh;
    acc_nxt   = acc_sh;
    cnt_nxt   = cnt_sh;
    if (accept && sym_hit) begin
      acc_nxt = acc_sh | code_al;
      cnt_nxt = cnt_sh + CNT_W'(sym_len);
    end
    emit_part = (state == FLUSH) && (cnt < CNT_W'(O_W)) && (cnt != '0) && slot_free;
    if (emit_part) begin
      acc_nxt = '0;
      cnt_nxt = '0;
    end

    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = FLUSH;
      FLUSH:   if ((cnt < CNT_W'(O_W)) && slot_free) state_nxt = FDONE;
      FDONE:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (new_conf) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (conf_wr) begin
      tbl_code[d_conf] <= h_conf;
      tbl_len[d_conf]  <= w_conf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_vld      <= '0;
      acc          <= '0;
      cnt          <= '0;
      o_word       <= '0;
      o_bits       <= '0;
      o_last       <= 1'b0;
      o_valid      <= 1'b0;
      err_unmapped <= 1'b0;
      flush_done   <= 1'b0;
    end else if (new_conf) begin
      tbl_vld      <= '0;
      acc          <= '0;
      cnt          <= '0;
      o_last       <= 1'b0;
      o_valid      <= 1'b0;
      err_unmapped <= 1'b0;
      flush_done   <= 1'b0;
    end else begin
      if (conf_wr) tbl_vld[d_conf] <= 1'b1;
      acc          <= acc_nxt;
      cnt          <= cnt_nxt;
      err_unmapped <= accept && !sym_hit;
      flush_done   <= (state == FDONE);
      if (emit_full) begin
        o_word  <= acc[AW-1 -: O_W];
        o_bits  <= OB_W'(O_W);
        o_last  <= 1'b0;
        o_valid <= 1'b1;
      end else if (emit_part) begin
        // Bits below cnt are always zero in acc, so the top slice is already padded.
        o_word  <= acc[AW-1 -: O_W];
        o_bits  <= OB_W'(cnt);
        o_last  <= 1'b1;
        o_valid <= 1'b1;
      end else if (o_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end
endmodule
